// File: rtl/palette_encoder.sv
// ---------------------------------------------------------------------------
// palette_encoder
//
// Converts a 24-bit RGB pixel stream into 4-bit palette indices. It packs
// four indices into each 16-bit word and writes the words one after another
// into sprite/tile RAM, starting at a caller-supplied base address.
//
// Palette (inverse of the display colour lookup):
//   0 : blue background gradient (R=G=0, B!=0)
//   1 : black
//   2 : white
//   anything else is unmapped: it encodes as PAD_IDX and bumps err_count.
//
// Ports:
//   Clk, Reset_n         rising-edge clock, asynchronous active-low reset
//   start, base_addr     begin an image (honoured only while idle)
//   in_valid/in_ready    pixel handshake; in_R/in_G/in_B colour, in_last end
//   mem_we/mem_ready     RAM write handshake; mem_addr/mem_wdata held while
//                        mem_ready is low
//   busy                 high whenever an image is in progress
//   done                 one-cycle pulse after the final word is written
//   err_count            unmapped pixels in this image (saturating)
//   word_count           words written in this image
// ---------------------------------------------------------------------------
module palette_encoder #(
    parameter int          ADDR_W  = 16,
    parameter int          ERR_W   = 8,
    parameter logic [3:0]  PAD_IDX = 4'hF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_R,
    input  logic [7:0]        in_G,
    input  logic [7:0]        in_B,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Returns {unmapped, index}; the colour tests are evaluated in priority order.
    function automatic logic [4:0] encode_pixel(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
        logic [4:0] res;
        if ((r == 8'h00) && (g == 8'h00) && (b == 8'h00)) begin
            res = {1'b0, 4'd1};
        end else if ((r == 8'hFF) && (g == 8'hFF) && (b == 8'hFF)) begin
            res = {1'b0, 4'd2};
        end else if ((r == 8'h00) && (g == 8'h00)) begin
            res = {1'b0, 4'd0};
        end else begin
            res = {1'b1, PAD_IDX};
        end
        return res;
    endfunction

    state_t              state_r;
    state_t              state_n_s;
    logic [1:0]          nib_cnt_r;
    logic [15:0]         pack_r;
    logic [15:0]         pack_next_s;
    logic                last_seen_r;
    logic [4:0]          enc_s;
    logic                fire_s;
    logic                word_end_s;

    logic                in_ready_r;
    logic                mem_we_r;
    logic                busy_r;
    logic                done_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [15:0]         mem_wdata_r;
    logic [ERR_W-1:0]    err_count_r;
    logic [ADDR_W-1:0]   word_count_r;

    assign enc_s      = encode_pixel(in_R, in_G, in_B);
    assign fire_s     = (state_r == ST_ACCEPT) && in_valid;
    assign word_end_s = (nib_cnt_r == 2'd3) || in_last;

    // Merge the freshly encoded index into its nibble slot of the pack register.
    always_comb begin
        pack_next_s = pack_r;
        case (nib_cnt_r)
            2'd0:    pack_next_s = {pack_r[15:4], enc_s[3:0]};
            2'd1:    pack_next_s = {pack_r[15:8], enc_s[3:0], pack_r[3:0]};
            2'd2:    pack_next_s = {pack_r[15:12], enc_s[3:0], pack_r[7:0]};
            2'd3:    pack_next_s = {enc_s[3:0], pack_r[11:0]};
            default: pack_next_s = pack_r;
        endcase
    end

    // Next-state decode for the image sequencer.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n_s = ST_ACCEPT;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (fire_s && word_end_s) begin
                    state_n_s = ST_WRITE;
                end else begin
                    state_n_s = ST_ACCEPT;
                end
            end
            ST_WRITE: begin
                if (!mem_ready) begin
                    state_n_s = ST_WRITE;
                end else if (last_seen_r) begin
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_ACCEPT;
                end
            end
            ST_DONE: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register plus control outputs, registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            in_ready_r <= (state_n_s == ST_ACCEPT);
            mem_we_r   <= (state_n_s == ST_WRITE);
            busy_r     <= (state_n_s != ST_IDLE);
            done_r     <= (state_n_s == ST_DONE);
        end
    end

    // Datapath: packing, write address/data, and per-image counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nib_cnt_r    <= 2'd0;
            pack_r       <= 16'h0000;
            last_seen_r  <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 16'h0000;
            err_count_r  <= {ERR_W{1'b0}};
            word_count_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr_r   <= base_addr;
                        nib_cnt_r    <= 2'd0;
                        err_count_r  <= {ERR_W{1'b0}};
                        word_count_r <= {ADDR_W{1'b0}};
                        pack_r       <= {4{PAD_IDX}};
                        last_seen_r  <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (fire_s) begin
                        pack_r <= pack_next_s;
                        if (enc_s[4] && (err_count_r != {ERR_W{1'b1}})) begin
                            err_count_r <= err_count_r + ERR_W'(1);
                        end
                        if (word_end_s) begin
                            mem_wdata_r <= pack_next_s;
                            last_seen_r <= in_last;
                        end else begin
                            nib_cnt_r <= nib_cnt_r + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_addr_r   <= mem_addr_r + ADDR_W'(1);
                        word_count_r <= word_count_r + ADDR_W'(1);
                        nib_cnt_r    <= 2'd0;
                        pack_r       <= {4{PAD_IDX}};
                    end
                end
                default: begin
                    nib_cnt_r <= nib_cnt_r;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign mem_we     = mem_we_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign err_count  = err_count_r;
    assign word_count = word_count_r;

endmodule

// File: doc/palette_encoder.md
Name: palette_encoder

Overview:
- Encoder side of the sprite colour path: converts an incoming 24-bit RGB pixel stream (sprite art load or frame capture) into 4-bit palette indices.
- Packs four indices per 16-bit word and writes the words sequentially into sprite/tile RAM.
- Its palette is the inverse of the display colour lookup: index 0 is the blue background gradient, index 1 is black, index 2 is white.
- Sits between the pixel source (DMA or test loader) and the sprite memory write port.

Parameters:
- ADDR_W, 16, width of the RAM word address.
- ERR_W, 8, width of the unmapped-pixel counter (saturating).
- PAD_IDX, 4'hF, index used to pad a partial final word.

Ports:
- Clk  input  1  system clock; all state is rising-edge.
- Reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins an image; honoured only in IDLE.
- base_addr  input  ADDR_W  first word address; sampled on start.
- in_valid  input  1  pixel valid.
- in_ready  output  1  pixel accepted when in_valid && in_ready.
- in_R, in_G, in_B  input  8 each  pixel colour.
- in_last  input  1  marks the final pixel of the image; qualified by the handshake.
- mem_we  output  1  write request; held until mem_ready.
- mem_ready  input  1  RAM accepts the write this cycle.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  16  packed indices; first pixel in [3:0], fourth pixel in [15:12].
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last word is written.
- err_count  output  ERR_W  unmapped pixels in the current image; saturating.
- word_count  output  ADDR_W  words written in the current image.

Behaviour:
- Encoding is combinational on the accepted pixel, in priority order:
  - R=G=B=8'h00 -> 1.
  - R=G=B=8'hFF -> 2.
  - R=8'h00, G=8'h00, B!=8'h00 -> 0.
  - Anything else -> PAD_IDX, and err_count increments, saturating at all-ones.
- Reset: state IDLE; in_ready, mem_we, busy and done are 0; mem_addr, mem_wdata, err_count, word_count and the nibble counter are 0.
- Reset asserted mid-image aborts it with no done pulse; a pending write is dropped.
- IDLE:
  - in_ready=0.
  - On start: mem_addr<=base_addr, nib_cnt<=0, err_count<=0, word_count<=0, pack register <= {4{PAD_IDX}}; go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On handshake, write the encoded index into nibble nib_cnt of the pack register.
  - If nib_cnt==3 or in_last: latch the pack register (including the new nibble) into mem_wdata, set last_seen<=in_last, go to WRITE.
  - Otherwise nib_cnt++.
  - Unwritten nibbles of a partial word remain PAD_IDX.
- WRITE:
  - mem_we=1 and in_ready=0; mem_addr and mem_wdata stay stable while mem_ready=0.
  - On mem_ready: mem_addr++ (wraps modulo 2^ADDR_W), word_count++, nib_cnt<=0, pack register <= {4{PAD_IDX}}.
  - Then go to DONE if last_seen, else ACCEPT.
- DONE: done=1 for exactly one cycle; go to IDLE next cycle. busy drops in IDLE.
- start outside IDLE is ignored. in_valid outside ACCEPT is not consumed.
- Latency: the pixel completing a word is accepted at cycle N; mem_we is asserted at N+1. Peak throughput is 4 pixels per 5 cycles with mem_ready tied high.
- If in_last arrives with nib_cnt==3, exactly one word is written; no empty pad word follows.
- An image with a single pixel produces one word with three PAD_IDX nibbles.

Test Plan:
- Reset, then base_addr=16'h0100, start; 4 pixels white, black, (0,0,7F), white with last on the 4th -> one write at 16'h0100, wdata 16'h2012, done pulse, word_count=1, err_count=0.
- 6 pixels, all black, last on the 6th -> writes 16'h1111 at base, then 16'hFF11 at base+1; done once; word_count=2.
- Pixel (80,10,20) among 3 whites, last on the 4th -> wdata has 4'hF in that nibble; err_count=1.
- Hold mem_ready=0 for 5 cycles during WRITE -> mem_we, mem_addr and mem_wdata stable, in_ready=0, no pixel consumed; write completes on the first mem_ready=1 cycle.
- base_addr=16'hFFFF, 8 pixels -> writes at 16'hFFFF then 16'h0000 (wrap).
- Assert Reset_n low while in WRITE -> outputs return to reset values immediately, no done; a following start runs a normal image correctly.
